// File: rtl/ps2_ascii_decoder.sv
// PS/2 set-2 scan-code to ASCII decoder with a queued output stream.
// Tracks F0/E0 prefixes, shift keys and caps-lock, translates printable
// make codes to ASCII and buffers them in a small FIFO drained over
// ascii_valid/ascii_ready.
module ps2_ascii_decoder #(
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         scan_valid,
  input  logic [7:0]                   scan_code,
  output logic                         ascii_valid,
  output logic [7:0]                   ascii_data,
  input  logic                         ascii_ready,
  output logic                         shift_held,
  output logic                         caps_lock,
  output logic                         overflow,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  localparam logic [7:0] CODE_BRK    = 8'hF0;
  localparam logic [7:0] CODE_EXT    = 8'hE0;
  localparam logic [7:0] CODE_LSHIFT = 8'h12;
  localparam logic [7:0] CODE_RSHIFT = 8'h59;
  localparam logic [7:0] CODE_CAPS   = 8'h58;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BRK     = 2'd1,
    ST_EXT     = 2'd2,
    ST_EXT_BRK = 2'd3
  } state_e;

  // Translate one make code; bit 8 flags a printable/mapped key.
  function automatic logic [8:0] map_code(input logic [7:0] code,
                                          input logic       shift,
                                          input logic       caps);
    logic [7:0] ch;
    logic       hit;
    logic       letter;
    ch     = 8'h00;
    hit    = 1'b1;
    letter = 1'b0;
    case (code)
      8'h1C: begin ch = 8'h61; letter = 1'b1; end
      8'h32: begin ch = 8'h62; letter = 1'b1; end
      8'h21: begin ch = 8'h63; letter = 1'b1; end
      8'h23: begin ch = 8'h64; letter = 1'b1; end
      8'h24: begin ch = 8'h65; letter = 1'b1; end
      8'h2B: begin ch = 8'h66; letter = 1'b1; end
      8'h34: begin ch = 8'h67; letter = 1'b1; end
      8'h33: begin ch = 8'h68; letter = 1'b1; end
      8'h43: begin ch = 8'h69; letter = 1'b1; end
      8'h3B: begin ch = 8'h6A; letter = 1'b1; end
      8'h42: begin ch = 8'h6B; letter = 1'b1; end
      8'h4B: begin ch = 8'h6C; letter = 1'b1; end
      8'h3A: begin ch = 8'h6D; letter = 1'b1; end
      8'h31: begin ch = 8'h6E; letter = 1'b1; end
      8'h44: begin ch = 8'h6F; letter = 1'b1; end
      8'h4D: begin ch = 8'h70; letter = 1'b1; end
      8'h15: begin ch = 8'h71; letter = 1'b1; end
      8'h2D: begin ch = 8'h72; letter = 1'b1; end
      8'h1B: begin ch = 8'h73; letter = 1'b1; end
      8'h2C: begin ch = 8'h74; letter = 1'b1; end
      8'h3C: begin ch = 8'h75; letter = 1'b1; end
      8'h2A: begin ch = 8'h76; letter = 1'b1; end
      8'h1D: begin ch = 8'h77; letter = 1'b1; end
      8'h22: begin ch = 8'h78; letter = 1'b1; end
      8'h35: begin ch = 8'h79; letter = 1'b1; end
      8'h1A: begin ch = 8'h7A; letter = 1'b1; end
      8'h45: ch = shift ? 8'h29 : 8'h30;
      8'h16: ch = shift ? 8'h21 : 8'h31;
      8'h1E: ch = shift ? 8'h40 : 8'h32;
      8'h26: ch = shift ? 8'h23 : 8'h33;
      8'h25: ch = shift ? 8'h24 : 8'h34;
      8'h2E: ch = shift ? 8'h25 : 8'h35;
      8'h36: ch = shift ? 8'h5E : 8'h36;
      8'h3D: ch = shift ? 8'h26 : 8'h37;
      8'h3E: ch = shift ? 8'h2A : 8'h38;
      8'h46: ch = shift ? 8'h28 : 8'h39;
      8'h29: ch = 8'h20;
      8'h5A: ch = 8'h0D;
      8'h66: ch = 8'h08;
      default: hit = 1'b0;
    endcase
    // Letters are uppercase when exactly one of shift / caps-lock is active.
    if (letter && (shift ^ caps)) begin
      ch = ch & 8'hDF;
    end
    return {hit, ch};
  endfunction

  state_e          state_q, state_d;
  logic            lshift_q, lshift_d;
  logic            rshift_q, rshift_d;
  logic            caps_down_q, caps_down_d;
  logic            caps_lock_q, caps_lock_d;
  logic            overflow_q, overflow_d;
  logic [AW-1:0]   rd_q, rd_d;
  logic [AW-1:0]   wr_q, wr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            ascii_valid_q, ascii_valid_d;
  logic [7:0]      ascii_data_q, ascii_data_d;
  logic            shift_held_q, shift_held_d;
  logic [7:0]      mem_q [FIFO_DEPTH];

  logic [8:0]      map_res;
  logic            push_req;
  logic            push_ok;
  logic            pop;
  logic            full;

  // Byte decode: prefix FSM, modifier tracking, FIFO pointer/count update.
  always_comb begin
    state_d       = state_q;
    lshift_d      = lshift_q;
    rshift_d      = rshift_q;
    caps_down_d   = caps_down_q;
    caps_lock_d   = caps_lock_q;
    overflow_d    = overflow_q;
    push_req      = 1'b0;

    map_res = map_code(scan_code, lshift_q | rshift_q, caps_lock_q);

    if (scan_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (scan_code == CODE_BRK) begin
            state_d = ST_BRK;
          end else if (scan_code == CODE_EXT) begin
            state_d = ST_EXT;
          end else if (scan_code == CODE_LSHIFT) begin
            lshift_d = 1'b1;
          end else if (scan_code == CODE_RSHIFT) begin
            rshift_d = 1'b1;
          end else if (scan_code == CODE_CAPS) begin
            // Auto-repeat of a held caps key must not re-toggle.
            if (!caps_down_q) begin
              caps_lock_d = ~caps_lock_q;
              caps_down_d = 1'b1;
            end
          end else begin
            push_req = map_res[8];
          end
        end
        ST_BRK: begin
          if (scan_code == CODE_LSHIFT) lshift_d = 1'b0;
          if (scan_code == CODE_RSHIFT) rshift_d = 1'b0;
          if (scan_code == CODE_CAPS)   caps_down_d = 1'b0;
          state_d = ST_IDLE;
        end
        ST_EXT: begin
          state_d = (scan_code == CODE_BRK) ? ST_EXT_BRK : ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    full    = (count_q == CW'(FIFO_DEPTH));
    pop     = (count_q != '0) & ascii_ready;
    push_ok = push_req & (~full | pop);
    if (push_req & full & ~pop) begin
      overflow_d = 1'b1;
    end

    rd_d    = rd_q + AW'(pop);
    wr_d    = wr_q + AW'(push_ok);
    count_d = count_q + CW'(push_ok) - CW'(pop);

    // Head of the queue after this edge; a fresh push lands at the head
    // when the queue was empty or its only entry is being popped.
    ascii_valid_d = (count_d != '0);
    if (count_d == '0) begin
      ascii_data_d = 8'h00;
    end else if (push_ok && (wr_q == rd_d)) begin
      ascii_data_d = map_res[7:0];
    end else begin
      ascii_data_d = mem_q[rd_d];
    end

    shift_held_d = lshift_d | rshift_d;
  end

  // Control and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      lshift_q      <= 1'b0;
      rshift_q      <= 1'b0;
      caps_down_q   <= 1'b0;
      caps_lock_q   <= 1'b0;
      overflow_q    <= 1'b0;
      rd_q          <= '0;
      wr_q          <= '0;
      count_q       <= '0;
      ascii_valid_q <= 1'b0;
      ascii_data_q  <= 8'h00;
      shift_held_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      lshift_q      <= lshift_d;
      rshift_q      <= rshift_d;
      caps_down_q   <= caps_down_d;
      caps_lock_q   <= caps_lock_d;
      overflow_q    <= overflow_d;
      rd_q          <= rd_d;
      wr_q          <= wr_d;
      count_q       <= count_d;
      ascii_valid_q <= ascii_valid_d;
      ascii_data_q  <= ascii_data_d;
      shift_held_q  <= shift_held_d;
    end
  end

  // Character storage; contents are don't-care until pointed at.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_q] <= map_res[7:0];
    end
  end

  assign ascii_valid = ascii_valid_q;
  assign ascii_data  = ascii_data_q;
  assign shift_held  = shift_held_q;
  assign caps_lock   = caps_lock_q;
  assign overflow    = overflow_q;
  assign fifo_count  = count_q;

endmodule

// File: tb/tb_ps2_ascii_decoder.sv
// Directed bench for ps2_ascii_decoder: table of per-cycle vectors plus
// hand-written overflow and reset sequences.
module tb_ps2_ascii_decoder;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          rst_n;
  logic          scan_valid;
  logic [7:0]    scan_code;
  logic          ascii_valid;
  logic [7:0]    ascii_data;
  logic          ascii_ready;
  logic          shift_held;
  logic          caps_lock;
  logic          overflow;
  logic [CW-1:0] fifo_count;

  ps2_ascii_decoder #(.FIFO_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .scan_valid  (scan_valid),
    .scan_code   (scan_code),
    .ascii_valid (ascii_valid),
    .ascii_data  (ascii_data),
    .ascii_ready (ascii_ready),
    .shift_held  (shift_held),
    .caps_lock   (caps_lock),
    .overflow    (overflow),
    .fifo_count  (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [7:0] code;
    logic       rdy;
    logic       e_valid;
    logic [7:0] e_data;
    int         e_count;
    logic       e_shift;
    logic       e_caps;
    logic       e_ovf;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp;
  int   n_bad;

  function automatic void add(input logic v, input logic [7:0] code, input logic rdy,
                              input logic ev, input logic [7:0] ed, input int ec,
                              input logic esh, input logic ecaps, input logic eovf);
    vec_t t;
    t = '{v, code, rdy, ev, ed, ec, esh, ecaps, eovf};
    vecs.push_back(t);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic ev, input logic [7:0] ed,
                         input int ec, input logic esh, input logic ecaps, input logic eovf);
    chk({tag, ".valid"}, int'(ascii_valid), int'(ev));
    chk({tag, ".data"},  int'(ascii_data),  int'(ed));
    chk({tag, ".count"}, int'(fifo_count),  ec);
    chk({tag, ".shift"}, int'(shift_held),  int'(esh));
    chk({tag, ".caps"},  int'(caps_lock),   int'(ecaps));
    chk({tag, ".ovf"},   int'(overflow),    int'(eovf));
  endtask

  // Drive one cycle of inputs just after an edge, then sample after the next edge.
  task automatic cycle(input logic v, input logic [7:0] c, input logic r);
    scan_valid  = v;
    scan_code   = c;
    ascii_ready = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] letters [9];
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    scan_valid = 1'b0;
    scan_code = 8'h00;
    ascii_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 1'b0, 8'h00, 0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;

    // v, code, rdy | valid, data, count, shift, caps, ovf
    // plain letter with break
    add(1, 8'h1C, 0, 1, 8'h61, 1, 0, 0, 0);
    add(1, 8'hF0, 0, 1, 8'h61, 1, 0, 0, 0);
    add(1, 8'h1C, 0, 1, 8'h61, 1, 0, 0, 0);
    add(0, 8'h00, 1, 0, 8'h00, 0, 0, 0, 0);
    // shift: A ! a
    add(1, 8'h12, 0, 0, 8'h00, 0, 1, 0, 0);
    add(1, 8'h1C, 0, 1, 8'h41, 1, 1, 0, 0);
    add(1, 8'h16, 0, 1, 8'h41, 2, 1, 0, 0);
    add(1, 8'hF0, 0, 1, 8'h41, 2, 1, 0, 0);
    add(1, 8'h12, 0, 1, 8'h41, 2, 0, 0, 0);
    add(1, 8'h1C, 0, 1, 8'h41, 3, 0, 0, 0);
    add(0, 8'h00, 1, 1, 8'h21, 2, 0, 0, 0);
    add(0, 8'h00, 1, 1, 8'h61, 1, 0, 0, 0);
    add(0, 8'h00, 1, 0, 8'h00, 0, 0, 0, 0);
    // caps-lock with auto-repeat: A 1 a
    add(1, 8'h58, 0, 0, 8'h00, 0, 0, 1, 0);
    add(1, 8'h58, 0, 0, 8'h00, 0, 0, 1, 0);
    add(1, 8'hF0, 0, 0, 8'h00, 0, 0, 1, 0);
    add(1, 8'h58, 0, 0, 8'h00, 0, 0, 1, 0);
    add(1, 8'h1C, 0, 1, 8'h41, 1, 0, 1, 0);
    add(1, 8'h16, 0, 1, 8'h41, 2, 0, 1, 0);
    add(1, 8'h58, 0, 1, 8'h41, 2, 0, 0, 0);
    add(1, 8'hF0, 0, 1, 8'h41, 2, 0, 0, 0);
    add(1, 8'h58, 0, 1, 8'h41, 2, 0, 0, 0);
    add(1, 8'h1C, 0, 1, 8'h41, 3, 0, 0, 0);
    add(0, 8'h00, 1, 1, 8'h31, 2, 0, 0, 0);
    add(0, 8'h00, 1, 1, 8'h61, 1, 0, 0, 0);
    // simultaneous push and pop with a single entry
    add(1, 8'h29, 1, 1, 8'h20, 1, 0, 0, 0);
    add(0, 8'h00, 1, 0, 8'h00, 0, 0, 0, 0);
    // extended keys and stray break ignored
    add(1, 8'hE0, 0, 0, 8'h00, 0, 0, 0, 0);
    add(1, 8'h75, 0, 0, 8'h00, 0, 0, 0, 0);
    add(1, 8'hE0, 0, 0, 8'h00, 0, 0, 0, 0);
    add(1, 8'hF0, 0, 0, 8'h00, 0, 0, 0, 0);
    add(1, 8'h75, 0, 0, 8'h00, 0, 0, 0, 0);
    add(1, 8'hF0, 0, 0, 8'h00, 0, 0, 0, 0);
    add(1, 8'h12, 0, 0, 8'h00, 0, 0, 0, 0);
    add(1, 8'h29, 0, 1, 8'h20, 1, 0, 0, 0);
    add(0, 8'h00, 1, 0, 8'h00, 0, 0, 0, 0);
    // right shift digit, shift-independent backspace and enter
    add(1, 8'h59, 0, 0, 8'h00, 0, 1, 0, 0);
    add(1, 8'h45, 0, 1, 8'h29, 1, 1, 0, 0);
    add(1, 8'h66, 1, 1, 8'h08, 1, 1, 0, 0);
    add(1, 8'hF0, 0, 1, 8'h08, 1, 1, 0, 0);
    add(1, 8'h59, 0, 1, 8'h08, 1, 0, 0, 0);
    add(1, 8'h5A, 1, 1, 8'h0D, 1, 0, 0, 0);
    add(1, 8'h45, 1, 1, 8'h30, 1, 0, 0, 0);
    add(0, 8'h00, 1, 0, 8'h00, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      cycle(vecs[i].v, vecs[i].code, vecs[i].rdy);
      chk_all($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_data, vecs[i].e_count,
              vecs[i].e_shift, vecs[i].e_caps, vecs[i].e_ovf);
    end

    // Overflow: nine letters into an eight-deep queue with no consumer.
    letters = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43};
    for (int i = 0; i < 9; i++) begin
      cycle(1'b1, letters[i], 1'b0);
    end
    chk_all("ovf.full", 1'b1, 8'h61, 8, 1'b0, 1'b0, 1'b1);
    // Push 'k' while popping 'a' on a full queue.
    cycle(1'b1, 8'h42, 1'b1);
    chk_all("ovf.pushpop", 1'b1, 8'h62, 8, 1'b0, 1'b0, 1'b1);
    begin
      logic [7:0] exp_drain [8];
      exp_drain = '{8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h68, 8'h6B};
      for (int i = 0; i < 8; i++) begin
        chk($sformatf("drain%0d.data", i), int'(ascii_data), int'(exp_drain[i]));
        chk($sformatf("drain%0d.count", i), int'(fifo_count), 8 - i);
        cycle(1'b0, 8'h00, 1'b1);
      end
    end
    chk_all("ovf.empty", 1'b0, 8'h00, 0, 1'b0, 1'b0, 1'b1);

    // Reset mid-prefix with shift held and three characters queued.
    cycle(1'b1, 8'h12, 1'b0);
    cycle(1'b1, 8'h1C, 1'b0);
    cycle(1'b1, 8'h32, 1'b0);
    cycle(1'b1, 8'h21, 1'b0);
    cycle(1'b1, 8'hF0, 1'b0);
    chk_all("pre_rst", 1'b1, 8'h41, 3, 1'b1, 1'b0, 1'b1);
    scan_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 1'b0, 8'h00, 0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle(1'b1, 8'h1C, 1'b0);
    chk_all("post_rst", 1'b1, 8'h61, 1, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
